// File: rtl/screen_timing_if.sv
// screen_timing_if: beam-position and video-timing bundle produced by the
// screen timing generator and consumed by renderers / pixel pipelines.
//   sx_out, sy_out : current beam position (CORDW bits, unsigned)
//   hsync_out      : horizontal sync (level set by the generator's SYNC_POL)
//   vsync_out      : vertical sync
//   de_out         : data enable, high only inside the active picture
// Modports: master (the timing generator drives everything),
//           slave  (downstream logic reads everything).
interface screen_timing_if #(
  parameter int CORDW = 10
);
  logic [CORDW-1:0] sx_out;
  logic [CORDW-1:0] sy_out;
  logic             hsync_out;
  logic             vsync_out;
  logic             de_out;

  modport master (
    output sx_out,
    output sy_out,
    output hsync_out,
    output vsync_out,
    output de_out
  );

  modport slave (
    input sx_out,
    input sy_out,
    input hsync_out,
    input vsync_out,
    input de_out
  );
endinterface

// File: rtl/screen_timing.sv
// screen_timing: free-running raster timing generator (default 640x480 @ 60 Hz
// with a 25.175 MHz pixel clock). Two counters sweep the whole raster including
// blanking; sync and data-enable are decoded combinationally from the counter
// registers so they always line up with the position reported in the same cycle.
// Ports:
//   clk_in : pixel clock, everything on the rising edge
//   rst_in : asynchronous active-high reset, clears the beam position to 0,0
//   vid    : screen_timing_if master (sx_out, sy_out, hsync_out, vsync_out, de_out)
module screen_timing #(
  parameter int H_RES    = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_RES    = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0,
  parameter int CORDW    = 10
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  screen_timing_if.master        vid
);

  localparam int H_TOTAL   = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL   = V_RES + V_FP + V_SYNC + V_BP;
  localparam int HS_START  = H_RES + H_FP;
  localparam int HS_END    = H_RES + H_FP + H_SYNC;   // exclusive
  localparam int VS_START  = V_RES + V_FP;
  localparam int VS_END    = V_RES + V_FP + V_SYNC;   // exclusive

  localparam logic [CORDW-1:0] SX_LAST = CORDW'(H_TOTAL - 1);
  localparam logic [CORDW-1:0] SY_LAST = CORDW'(V_TOTAL - 1);
  localparam logic [CORDW-1:0] ONE     = CORDW'(1);

  logic [CORDW-1:0] sx_reg;
  logic [CORDW-1:0] sy_reg;
  logic             hs_window;
  logic             vs_window;

  // Raster counters: sx runs every clock, sy advances on the last pixel of a
  // line, and both wrap together on the last pixel of the last line.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      sx_reg <= '0;
      sy_reg <= '0;
    end else if (sx_reg == SX_LAST) begin
      sx_reg <= '0;
      if (sy_reg == SY_LAST) begin
        sy_reg <= '0;
      end else begin
        sy_reg <= sy_reg + ONE;
      end
    end else begin
      sx_reg <= sx_reg + ONE;
    end
  end

  // Zero-latency decodes of the current position.
  assign hs_window = (sx_reg >= CORDW'(HS_START)) && (sx_reg < CORDW'(HS_END));
  // Vertical sync covers whole lines, so it ignores sx entirely.
  assign vs_window = (sy_reg >= CORDW'(VS_START)) && (sy_reg < CORDW'(VS_END));

  assign vid.sx_out    = sx_reg;
  assign vid.sy_out    = sy_reg;
  assign vid.hsync_out = hs_window ? SYNC_POL : !SYNC_POL;
  assign vid.vsync_out = vs_window ? SYNC_POL : !SYNC_POL;
  assign vid.de_out    = (sx_reg < CORDW'(H_RES)) && (sy_reg < CORDW'(V_RES));

endmodule

// File: tb/tb_screen_timing.sv
// Bench for screen_timing. A default 640x480 instance covers reset, line wrap,
// the hsync window and a mid-frame asynchronous reset. A second, tiny-raster
// instance (15x10 clocks, active-high sync) sharing clock and reset covers the
// frame wrap, vsync window and frame marker within a short run.
module tb_screen_timing;

  logic clk_in;
  logic rst_in;

  screen_timing_if #(.CORDW(10)) v ();
  screen_timing_if #(.CORDW(4))  s ();

  screen_timing dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .vid    (v)
  );

  // Small raster: H 8+2+3+2 = 15, V 6+1+2+1 = 10, frame = 150 clocks.
  // hsync active (high) at sx 10..12, vsync active at sy 7..8, marker sy=6,sx=0.
  screen_timing #(
    .H_RES(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_RES(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .CORDW(4)
  ) dut_small (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .vid    (s)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    int n;    // clocks since reset release
    int sx;
    int sy;
    bit de;
    bit hs;
    bit vs;
  } vec_t;

  vec_t vecs [15];

  int  errors = 0;
  int  checks = 0;
  int  n = 0;
  bit  stats_on = 1'b0;

  int  hs_low0 = 0;    // big: hsync-low clocks on line 0
  int  de_hi0 = 0;     // big: de-high clocks on line 0
  int  vs_low_big = 0; // big: vsync-low clocks over the run
  int  s_vs = 0, s_hs = 0, s_de = 0, s_mark = 0;
  int  s_sx_hist [0:150];
  int  s_sy_hist [0:150];
  bit  s_vs_hist [0:150];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic sample();
    if (stats_on) begin
      if (n < 800) begin
        if (!v.hsync_out) hs_low0++;
        if (v.de_out) de_hi0++;
      end
      if (!v.vsync_out) vs_low_big++;
      if (n <= 150) begin
        s_sx_hist[n] = int'(s.sx_out);
        s_sy_hist[n] = int'(s.sy_out);
        s_vs_hist[n] = s.vsync_out;
      end
      if (n < 150) begin
        if (s.vsync_out) s_vs++;
        if (s.hsync_out) s_hs++;
        if (s.de_out) s_de++;
        if (s.sy_out == 4'd6 && s.sx_out == 4'd0) s_mark++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
    n++;
    sample();
  endtask

  initial begin
    vecs[0]  = '{n:0,    sx:0,   sy:0, de:1, hs:1, vs:1};
    vecs[1]  = '{n:1,    sx:1,   sy:0, de:1, hs:1, vs:1};
    vecs[2]  = '{n:639,  sx:639, sy:0, de:1, hs:1, vs:1};
    vecs[3]  = '{n:640,  sx:640, sy:0, de:0, hs:1, vs:1};
    vecs[4]  = '{n:655,  sx:655, sy:0, de:0, hs:1, vs:1};
    vecs[5]  = '{n:656,  sx:656, sy:0, de:0, hs:0, vs:1};
    vecs[6]  = '{n:751,  sx:751, sy:0, de:0, hs:0, vs:1};
    vecs[7]  = '{n:752,  sx:752, sy:0, de:0, hs:1, vs:1};
    vecs[8]  = '{n:799,  sx:799, sy:0, de:0, hs:1, vs:1};
    vecs[9]  = '{n:800,  sx:0,   sy:1, de:1, hs:1, vs:1};
    vecs[10] = '{n:801,  sx:1,   sy:1, de:1, hs:1, vs:1};
    vecs[11] = '{n:1439, sx:639, sy:1, de:1, hs:1, vs:1};
    vecs[12] = '{n:1440, sx:640, sy:1, de:0, hs:1, vs:1};
    vecs[13] = '{n:1456, sx:656, sy:1, de:0, hs:0, vs:1};
    vecs[14] = '{n:1599, sx:799, sy:1, de:0, hs:1, vs:1};

    // Reset held: outputs reflect position 0,0.
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    $display("reset held: sx=%0d sy=%0d de=%0b hs=%0b vs=%0b",
             v.sx_out, v.sy_out, v.de_out, v.hsync_out, v.vsync_out);
    chk("rst_sx", int'(v.sx_out), 0);
    chk("rst_sy", int'(v.sy_out), 0);
    chk("rst_de", int'(v.de_out), 1);
    chk("rst_hs", int'(v.hsync_out), 1);
    chk("rst_vs", int'(v.vsync_out), 1);
    chk("rst_small_hs", int'(s.hsync_out), 0);
    chk("rst_small_vs", int'(s.vsync_out), 0);

    // Release between edges; n counts clocks since release.
    rst_in = 1'b0;
    n = 0;
    stats_on = 1'b1;
    sample();

    for (int i = 0; i < 15; i++) begin
      while (n < vecs[i].n) tick();
      $display("vec n=%0d: sx=%0d sy=%0d de=%0b hs=%0b vs=%0b", n,
               v.sx_out, v.sy_out, v.de_out, v.hsync_out, v.vsync_out);
      chk($sformatf("v%0d_sx", i), int'(v.sx_out), vecs[i].sx);
      chk($sformatf("v%0d_sy", i), int'(v.sy_out), vecs[i].sy);
      chk($sformatf("v%0d_de", i), int'(v.de_out), int'(vecs[i].de));
      chk($sformatf("v%0d_hs", i), int'(v.hsync_out), int'(vecs[i].hs));
      chk($sformatf("v%0d_vs", i), int'(v.vsync_out), int'(vecs[i].vs));
    end

    // Line-0 window widths on the default raster.
    $display("line0: hsync low %0d clocks, de high %0d clocks", hs_low0, de_hi0);
    chk("line0_hs_low", hs_low0, 96);
    chk("line0_de_hi", de_hi0, 640);
    chk("big_vs_low_lines01", vs_low_big, 0);

    // Small raster: one full frame plus the wrap.
    $display("small frame: vs=%0d hs=%0d de=%0d markers=%0d", s_vs, s_hs, s_de, s_mark);
    chk("s_vs_clocks", s_vs, 30);
    chk("s_hs_clocks", s_hs, 30);
    chk("s_de_clocks", s_de, 48);
    chk("s_markers", s_mark, 1);
    chk("s_vs_at_104", int'(s_vs_hist[104]), 0);
    chk("s_vs_at_105", int'(s_vs_hist[105]), 1);
    chk("s_vs_at_134", int'(s_vs_hist[134]), 1);
    chk("s_vs_at_135", int'(s_vs_hist[135]), 0);
    chk("s_sx_149", s_sx_hist[149], 14);
    chk("s_sy_149", s_sy_hist[149], 9);
    chk("s_sx_150", s_sx_hist[150], 0);
    chk("s_sy_150", s_sy_hist[150], 0);
    chk("s_sy_15", s_sy_hist[15], 1);

    // Mid-frame asynchronous reset at sx=300, sy=2.
    while (n < 1900) tick();
    chk("pre_async_sx", int'(v.sx_out), 300);
    chk("pre_async_sy", int'(v.sy_out), 2);
    #2 rst_in = 1'b1;
    #1;
    $display("async reset: sx=%0d sy=%0d (before next edge)", v.sx_out, v.sy_out);
    chk("async_sx", int'(v.sx_out), 0);
    chk("async_sy", int'(v.sy_out), 0);
    @(negedge clk_in);
    chk("async_hold_sx", int'(v.sx_out), 0);
    stats_on = 1'b0;
    rst_in = 1'b0;
    n = 0;
    tick();
    $display("after release +1: sx=%0d sy=%0d", v.sx_out, v.sy_out);
    chk("resume_sx1", int'(v.sx_out), 1);
    repeat (10) tick();
    $display("after release +11: sx=%0d sy=%0d", v.sx_out, v.sy_out);
    chk("resume_sx11", int'(v.sx_out), 11);
    chk("resume_sy11", int'(v.sy_out), 0);
    chk("resume_small_sy", int'(s.sy_out), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_timing.md
Name: screen_timing

Overview:
- Free-running VGA timing generator for a 640x480 @ 60 Hz display, driven by the pixel clock.
- Produces the current beam position (sx, sy), the sync pulses and the data-enable qualifier.
- Downstream blocks (renderer, pixel pipeline) use it to decide pixel colour and frame boundaries, e.g. frame start at sy==480, sx==0.
- Counters cover the full raster including blanking.

Parameters:
- H_RES, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_RES, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low, 1 = active-high)
- CORDW, 10, width of sx/sy outputs

Ports:
- clk_in  input  1  pixel clock (25.175 MHz nominal); all logic on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- sx_out  output CORDW  horizontal position, 0..H_TOTAL-1
- sy_out  output CORDW  vertical position, 0..V_TOTAL-1
- hsync_out  output 1  horizontal sync
- vsync_out  output 1  vertical sync
- de_out  output 1  data enable, high only in the active area

Behaviour:
- Derived constants:
  - H_TOTAL = H_RES+H_FP+H_SYNC+H_BP = 800
  - V_TOTAL = V_RES+V_FP+V_SYNC+V_BP = 525
- Counters:
  - sx and sy are registers driven directly to sx_out/sy_out, unsigned.
  - Every clock sx increments.
  - When sx == H_TOTAL-1: sx wraps to 0 and sy increments.
  - When sx == H_TOTAL-1 and sy == V_TOTAL-1: both wrap to 0.
  - Frame period is exactly 800*525 = 420000 clocks; line period is 800 clocks.
- Decodes:
  - hsync_out, vsync_out and de_out are combinational decodes of the current sx/sy registers: zero latency, always consistent with sx_out/sy_out in the same cycle.
- de_out = (sx < H_RES) && (sy < V_RES). Low throughout horizontal and vertical blanking.
- hsync_out:
  - Active (== SYNC_POL) when H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC, i.e. sx 656..751.
  - Inactive (== !SYNC_POL) otherwise.
- vsync_out:
  - Active when V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC, i.e. sy 490..491, for the whole of those lines (independent of sx).
  - Inactive otherwise.
- Reset:
  - While rst_in is high: sx=0, sy=0.
  - Outputs therefore read sx_out=0, sy_out=0, de_out=1, hsync_out=!SYNC_POL, vsync_out=!SYNC_POL.
  - Assertion mid-frame clears the counters immediately, without waiting for a clock edge.
  - The first clock edge after deassertion advances sx to 1.
- No enable or stall input; the block never stops counting outside reset.
- Counter width: CORDW must hold H_TOTAL-1 and V_TOTAL-1. The 10-bit default suffices; counters never reach values outside the ranges above.

Test Plan:
- Reset: hold rst_in high, then release -> sx_out=0, sy_out=0, de_out=1, hsync_out=1, vsync_out=1; one clock later sx_out=1.
- Line wrap: run to sx=799, sy=0 -> next clock sx=0, sy=1; de_out low for sx 640..799, high for sx 0..639.
- Hsync window: on line 0 -> hsync_out=0 exactly at sx 656..751 (96 clocks), 1 at sx 655 and 752.
- Frame wrap and vsync: run a full frame -> vsync_out=0 only for sy 490..491 (1600 clocks); at sx=799, sy=524 next state is sx=0, sy=0; frame length 420000 clocks.
- Frame marker: at sy=480, sx=0 -> de_out=0, hsync_out=1, vsync_out=1; this condition occurs exactly once per frame.
- Async reset mid-frame: assert rst_in between clock edges at sx=300, sy=200 -> sx_out/sy_out go to 0 before the next edge; counting resumes from 0 after release.
